// File: rtl/gpu_pkg.sv
// Shared opcodes, scheduler state encoding and default field widths for the
// GPU command scheduler slice.
package gpu_pkg;

    localparam int OPW_DEF = 4;
    localparam int PRW_DEF = 25;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_FENCE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FENCE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Command FIFO with a combinational head read. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module gpu_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = OPW_DEF + PRW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Status flags, head read and accepted push/pop qualification
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        rdata     = mem_r[rd_ptr_r];
        count     = count_r;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Dispatches buffered GPU commands to the draw engine one at a time,
// discarding NOPs and stalling on FENCE until the engine reports idle.
module gpu_cmd_scheduler
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OPW   = OPW_DEF,
    parameter int PRW   = PRW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   command_i,
    input  logic [OPW-1:0]         opcode_i,
    input  logic [PRW-1:0]         parameters_i,
    output logic                   cmd_valid_o,
    output logic [OPW-1:0]         cmd_opcode_o,
    output logic [PRW-1:0]         cmd_params_o,
    input  logic                   cmd_ready_i,
    input  logic                   engine_busy_i,
    input  logic                   clear_i,
    output logic                   fence_pending_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int W  = OPW + PRW;
    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t   state_r;
    sched_state_t   next_state_s;
    logic           pop_s;
    logic           load_s;
    logic           drop_s;
    logic           full_s;
    logic           empty_s;
    logic [W-1:0]   head_s;
    logic [OPW-1:0] head_op_s;
    logic [PRW-1:0] head_prm_s;
    logic [CW-1:0]  count_s;

    logic           cmd_valid_r;
    logic [OPW-1:0] cmd_opcode_r;
    logic [PRW-1:0] cmd_params_r;
    logic           fence_pending_r;
    logic           overflow_r;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (command_i),
        .pop   (pop_s),
        .wdata ({opcode_i, parameters_i}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign head_op_s  = head_s[W-1:PRW];
    assign head_prm_s = head_s[PRW-1:0];

    // A push is dropped only when the FIFO is full and nothing leaves this cycle
    assign drop_s = command_i && full_s && !pop_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, pop and output-load decisions
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_op_s == OPW'(OP_NOP)) begin
                        next_state_s = IDLE;
                    end else if (head_op_s == OPW'(OP_FENCE)) begin
                        next_state_s = FENCE;
                    end else begin
                        next_state_s = ISSUE;
                        load_s       = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_ready_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            FENCE: begin
                if (!engine_busy_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FENCE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Engine-side output registers; data keeps its last value after a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r     <= 1'b0;
            cmd_opcode_r    <= {OPW{1'b0}};
            cmd_params_r    <= {PRW{1'b0}};
            fence_pending_r <= 1'b0;
        end else begin
            cmd_valid_r     <= (next_state_s == ISSUE);
            fence_pending_r <= (next_state_s == FENCE);
            if (load_s) begin
                cmd_opcode_r <= head_op_s;
                cmd_params_r <= head_prm_s;
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_i) begin
            overflow_r <= 1'b0;
        end
    end

    assign cmd_valid_o     = cmd_valid_r;
    assign cmd_opcode_o    = cmd_opcode_r;
    assign cmd_params_o    = cmd_params_r;
    assign fence_pending_o = fence_pending_r;
    assign overflow_o      = overflow_r;
    assign count_o         = count_s;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Scenario-driven bench for gpu_cmd_scheduler: expected dispatches are queued
// when pushed and compared by a monitor on every valid/ready transfer.
module tb_gpu_cmd_scheduler;
    import gpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int OPW   = 4;
    localparam int PRW   = 25;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [PRW-1:0] prm;
    } cmd_t;

    logic           clk;
    logic           rst;
    logic           command_i;
    logic [OPW-1:0] opcode_i;
    logic [PRW-1:0] parameters_i;
    logic           cmd_valid_o;
    logic [OPW-1:0] cmd_opcode_o;
    logic [PRW-1:0] cmd_params_o;
    logic           cmd_ready_i;
    logic           engine_busy_i;
    logic           clear_i;
    logic           fence_pending_o;
    logic           overflow_o;
    logic [CW-1:0]  count_o;

    cmd_t           exp_q[$];
    cmd_t           mon_e;
    int             errors   = 0;
    int             checks   = 0;
    int             xfer_cnt = 0;
    logic           prev_stall = 1'b0;
    logic [OPW-1:0] prev_op;
    logic [PRW-1:0] prev_prm;

    gpu_cmd_scheduler #(
        .DEPTH (DEPTH),
        .OPW   (OPW),
        .PRW   (PRW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .command_i       (command_i),
        .opcode_i        (opcode_i),
        .parameters_i    (parameters_i),
        .cmd_valid_o     (cmd_valid_o),
        .cmd_opcode_o    (cmd_opcode_o),
        .cmd_params_o    (cmd_params_o),
        .cmd_ready_i     (cmd_ready_i),
        .engine_busy_i   (engine_busy_i),
        .clear_i         (clear_i),
        .fence_pending_o (fence_pending_o),
        .overflow_o      (overflow_o),
        .count_o         (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor: scoreboard compare and hold-while-stalled check
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (cmd_valid_o !== 1'b1 || cmd_opcode_o !== prev_op || cmd_params_o !== prev_prm) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b op=%h prm=%h, want valid=1 op=%h prm=%h",
                             cmd_valid_o, cmd_opcode_o, cmd_params_o, prev_op, prev_prm);
                end
            end
            if (cmd_valid_o === 1'b1 && cmd_ready_i === 1'b1) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got op=%h prm=%h, want no transfer",
                             cmd_opcode_o, cmd_params_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (cmd_opcode_o !== mon_e.op || cmd_params_o !== mon_e.prm) begin
                        errors++;
                        $display("FAIL xfer_data: got op=%h prm=%h, want op=%h prm=%h",
                                 cmd_opcode_o, cmd_params_o, mon_e.op, mon_e.prm);
                    end
                end
            end
            prev_stall = cmd_valid_o && !cmd_ready_i;
            prev_op    = cmd_opcode_o;
            prev_prm   = cmd_params_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives command_i for the current cycle and records what should reach the engine
    task automatic push_cycle(input logic [OPW-1:0] op, input logic [PRW-1:0] prm, input bit accept);
        command_i    = 1'b1;
        opcode_i     = op;
        parameters_i = prm;
        if (accept && op != OP_NOP && op != OP_FENCE) begin
            exp_q.push_back({op, prm});
        end
        tick();
        command_i = 1'b0;
    endtask

    task automatic wait_drained(input int max_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d commands outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        command_i = 1'b0; opcode_i = 4'h0; parameters_i = 25'h0;
        cmd_ready_i = 1'b0; engine_busy_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b0 || cmd_opcode_o !== 4'h0 || cmd_params_o !== 25'h0) begin
            errors++;
            $display("FAIL reset_cmd: got valid=%0b op=%h prm=%h, want 0 0 0", cmd_valid_o, cmd_opcode_o, cmd_params_o);
        end
        checks++;
        if (fence_pending_o !== 1'b0 || overflow_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_status: got fence=%0b ovf=%0b count=%0d, want 0 0 0", fence_pending_o, overflow_o, count_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        cmd_ready_i = 1'b1;
        push_cycle(4'h3, 25'h0000ABC, 1'b1);
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1_valid: got %0b, want 0", cmd_valid_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b1 || cmd_opcode_o !== 4'h3 || cmd_params_o !== 25'h0000ABC) begin
            errors++;
            $display("FAIL single_cycle2: got valid=%0b op=%h prm=%h, want 1 3 0000abc", cmd_valid_o, cmd_opcode_o, cmd_params_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL single_cycle3: got valid=%0b count=%0d, want 0 0", cmd_valid_o, count_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n = 0;
        int x0;
        cmd_ready_i = 1'b0;
        push_cycle(4'h5, 25'h1234567, 1'b1);
        @(negedge clk);
        while (cmd_valid_o !== 1'b1 && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_timeout: got valid=%0b, want 1", cmd_valid_o);
        end
        x0 = xfer_cnt;
        repeat (4) begin
            tick();
            @(negedge clk);
            checks++;
            if (cmd_valid_o !== 1'b1 || cmd_opcode_o !== 4'h5) begin
                errors++;
                $display("FAIL bp_stalled: got valid=%0b op=%h, want 1 5", cmd_valid_o, cmd_opcode_o);
            end
        end
        tick();
        cmd_ready_i = 1'b1;
        @(negedge clk);
        tick();
        cmd_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b0 || (xfer_cnt - x0) != 1) begin
            errors++;
            $display("FAIL bp_one_xfer: got valid=%0b xfers=%0d, want 0 1", cmd_valid_o, xfer_cnt - x0);
        end
        tick();
    endtask

    task automatic test_nop_fence();
        int n = 0;
        cmd_ready_i   = 1'b1;
        engine_busy_i = 1'b1;
        push_cycle(OP_NOP,   25'h0000111, 1'b1);
        push_cycle(OP_FENCE, 25'h0000000, 1'b1);
        push_cycle(4'h2,     25'h0000222, 1'b1);
        @(negedge clk);
        while (fence_pending_o !== 1'b1 && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (fence_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL fence_timeout: got fence=%0b, want 1", fence_pending_o);
        end
        repeat (5) begin
            tick();
            @(negedge clk);
            checks++;
            if (fence_pending_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL fence_hold: got fence=%0b valid=%0b, want 1 0", fence_pending_o, cmd_valid_o);
            end
        end
        tick();
        engine_busy_i = 1'b0;
        @(negedge clk);
        checks++;
        if (fence_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL fence_busy_fall: got fence=%0b, want 1", fence_pending_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (fence_pending_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fence_release: got fence=%0b valid=%0b, want 0 0", fence_pending_o, cmd_valid_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b1 || cmd_opcode_o !== 4'h2) begin
            errors++;
            $display("FAIL fence_after_issue: got valid=%0b op=%h, want 1 2", cmd_valid_o, cmd_opcode_o);
        end
        tick();
        wait_drained(10, "fence");
    endtask

    task automatic test_fence_idle();
        int n = 0;
        engine_busy_i = 1'b0;
        push_cycle(OP_FENCE, 25'h0000000, 1'b1);
        repeat (8) begin
            @(negedge clk);
            if (fence_pending_o === 1'b1) n++;
            tick();
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL fence_idle_len: got %0d cycles, want 1", n);
        end
    endtask

    task automatic test_overflow_full();
        cmd_ready_i = 1'b0;
        // First push moves into the output register, the FIFO fills on the 9th,
        // so the 10th back-to-back push is the one dropped.
        for (int i = 0; i < 10; i++) begin
            push_cycle(OPW'(i + 1), PRW'(32'h100 + i), (i < 9));
        end
        @(negedge clk);
        checks++;
        if (count_o !== 4'd8 || overflow_o !== 1'b1 || cmd_valid_o !== 1'b1 || cmd_opcode_o !== 4'h1) begin
            errors++;
            $display("FAIL ovf_full: got count=%0d ovf=%0b valid=%0b op=%h, want 8 1 1 1",
                     count_o, overflow_o, cmd_valid_o, cmd_opcode_o);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %0b, want 1", overflow_o);
        end
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %0b, want 0", overflow_o);
        end
        tick();
        // Release one command; the next cycle pops while full, so a push must land
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        push_cycle(4'hB, 25'h1BADB0B, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || cmd_valid_o !== 1'b1 || cmd_opcode_o !== 4'h2) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d ovf=%0b valid=%0b op=%h, want 8 0 1 2",
                     count_o, overflow_o, cmd_valid_o, cmd_opcode_o);
        end
        tick();
        cmd_ready_i = 1'b1;
        wait_drained(60, "drain");
        tick();
        @(negedge clk);
        checks++;
        if (count_o !== 4'd0 || cmd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got count=%0d valid=%0b, want 0 0", count_o, cmd_valid_o);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        cmd_ready_i = 1'b0;
        push_cycle(4'h7, 25'h0000777, 1'b1);
        push_cycle(4'h8, 25'h0000888, 1'b1);
        push_cycle(4'h9, 25'h0000999, 1'b1);
        push_cycle(4'hA, 25'h0000AAA, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b0 || cmd_opcode_o !== 4'h0 || cmd_params_o !== 25'h0 ||
            fence_pending_o !== 1'b0 || overflow_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b op=%h prm=%h fence=%0b ovf=%0b count=%0d, want all 0",
                     cmd_valid_o, cmd_opcode_o, cmd_params_o, fence_pending_o, overflow_o, count_o);
        end
        tick();
        cmd_ready_i = 1'b1;
        push_cycle(4'h6, 25'h0000666, 1'b1);
        wait_drained(10, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_nop_fence();
        test_fence_idle();
        test_overflow_full();
        test_mid_reset();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1);
    end

endmodule
